muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-003 SHALL have port startE, input, 1 bit: start request from EX stage (hlwriteE & ~flushE).
REQ-004 SHALL have port multordivE, input, 1 bit: 0 = multiply, 1 = divide.
REQ-005 SHALL have port signedE, input, 1 bit: 1 = signed operands (mult/div), 0 = unsigned (multu/divu).
REQ-006 SHALL have port srcaE, input, 32 bits: multiplicand or dividend.
REQ-007 SHALL have port srcbE, input, 32 bits: multiplier or divisor.
REQ-008 SHALL have port abortE, input, 1 bit: cancel an in-flight operation.
REQ-009 SHALL have port hiweW, input, 1 bit: mthi write enable.
REQ-010 SHALL have port loweW, input, 1 bit: mtlo write enable.
REQ-011 SHALL have port wdataW, input, 32 bits: data for mthi/mtlo.
REQ-012 SHALL have port busy, output, 1 bit: operation in flight; the hazard unit uses it to stall mfhi/mflo and mult/div in D.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when HI/LO are updated.
REQ-014 SHALL have ports hi and lo, output, 32 bits each: architectural HI/LO registers.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, FIX.
REQ-016 In IDLE with startE=1, edge E0 SHALL do all of the following: capture operand magnitudes (absolute value if signedE), record the result signs, clear the 6-bit iteration counter, go to RUN, set busy=1.
REQ-017 In RUN, edges E1..E32 SHALL each perform one step: shift-add for multiply, restoring shift-subtract for divide.
REQ-018 The counter SHALL increment once per RUN step; at the 32nd step the FSM SHALL move to FIX.
REQ-019 At edge E33 (FIX) the unit SHALL sign-correct the result, write hi/lo, assert done for exactly one cycle, clear busy, and return to IDLE.
REQ-020 Total latency SHALL be 33 cycles from the start edge to hi/lo valid.
REQ-021 Multiply SHALL produce the 64-bit product, with hi = bits [63:32] and lo = bits [31:0].
REQ-022 For signed multiply, the product SHALL be negated when the operand signs differ.
REQ-023 Divide SHALL set lo = quotient and hi = remainder.
REQ-024 For signed divide, the quotient SHALL be negative iff the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-025 Divide by zero SHALL give lo = 0xFFFFFFFF and hi = srcaE, for both signed and unsigned.
REQ-026 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0x00000000.
REQ-027 startE while busy=1 SHALL be ignored; the operands are not captured.
REQ-028 abortE=1 in RUN or FIX SHALL return the FSM to IDLE at the next edge, with hi/lo unchanged, done=0, and busy=0.
REQ-029 abortE in IDLE SHALL have no effect.
REQ-030 abortE and startE asserted together in IDLE SHALL give priority to abortE, and no operation starts.
REQ-031 In IDLE, hiweW/loweW SHALL write wdataW to hi/lo at the next edge.
REQ-032 hiweW/loweW asserted while busy=1 SHALL be ignored.
REQ-033 If startE and hiweW/loweW are asserted together in IDLE, the operation SHALL start and the direct write SHALL be dropped.
REQ-034 hi/lo SHALL change only at a FIX edge or on a direct write.

Reset
REQ-035 reset=0 SHALL asynchronously force state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, and clear all internal datapath registers.
REQ-036 Reset asserted mid-operation SHALL discard the operation; after reset is released, the first rising edge SHALL behave as IDLE.

Structure
REQ-037 The FSM state enum and the constants MULDIV_STEPS=32 and MULDIV_DIVZERO_LO=32'hFFFFFFFF SHALL live in the shared mips_pkg package.
REQ-038 The block SHALL be a single module (FSM, counter, 64-bit accumulator, 32-bit divisor/multiplicand register, sign flags) with no sub-module.

Verification
REQ-039 A bench SHALL check: signed mult 7 x -3 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB, one done pulse, busy high for exactly 33 cycles.
REQ-040 A bench SHALL check: unsigned div 100 / 7 -> lo=14, hi=2; signed div -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-041 A bench SHALL check: div 0x12345678 / 0 -> lo=0xFFFFFFFF, hi=0x12345678; signed 0x80000000 / -1 -> lo=0x80000000, hi=0.
REQ-042 A bench SHALL check: mthi 0xAAAA5555 with hi/lo previously 0/0, then start mult, then abortE at cycle 10 -> busy falls next cycle, no done pulse, hi=0xAAAA5555, lo=0.
REQ-043 A bench SHALL check: second startE and hiweW during busy -> ignored; the first result is written unchanged.
REQ-044 A bench SHALL check: reset=0 asserted at cycle 20 of an operation -> hi=lo=0 and busy=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS core.
package mips_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FIX} mulDivState_t;
    localparam int MULDIV_STEPS = 32;
    localparam logic [31:0] MULDIV_DIVZERO_LO = 32'hFFFFFFFF;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-step multiply/divide unit that owns the architectural HI/LO registers.
module muldiv_unit
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        startE,
    input  logic        multordivE,
    input  logic        signedE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        abortE,
    input  logic        hiweW,
    input  logic        loweW,
    input  logic [31:0] wdataW,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    mulDivState_t state;
    logic [5:0]  count;
    logic [63:0] acc;
    logic [31:0] opB;
    logic        isDiv, negQ, negR, divZero;
    logic [31:0] magA, magB;
    logic [32:0] mulSum;
    logic [33:0] divDiff;
    logic [63:0] stepAcc, product;
    logic [31:0] quot, rem, hiRes, loRes;

    assign magA = (signedE && srcaE[31]) ? -srcaE : srcaE;
    assign magB = (signedE && srcbE[31]) ? -srcbE : srcbE;

    // Multiply: acc holds {partial product, remaining multiplier bits}.
    // Divide: acc holds {partial remainder, dividend bits / quotient bits}.
    assign mulSum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opB} : 33'd0);
    assign divDiff = {1'b0, acc[63:31]} - {2'b0, opB};
    assign stepAcc = !isDiv ? {mulSum, acc[31:1]}
                   : divDiff[33] ? {acc[62:0], 1'b0}
                   : {divDiff[31:0], acc[30:0], 1'b1};

    assign product = negQ ? -acc : acc;
    // A zero divisor naturally leaves |dividend| as remainder; only the quotient needs forcing.
    assign quot  = divZero ? MULDIV_DIVZERO_LO : negQ ? -acc[31:0] : acc[31:0];
    assign rem   = negR ? -acc[63:32] : acc[63:32];
    assign hiRes = isDiv ? rem : product[63:32];
    assign loRes = isDiv ? quot : product[31:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= 6'd0;
            acc     <= 64'd0;
            opB     <= 32'd0;
            isDiv   <= 1'b0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
            divZero <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (startE && !abortE) begin
                        acc     <= {32'd0, magA};
                        opB     <= magB;
                        isDiv   <= multordivE;
                        negQ    <= signedE && (srcaE[31] ^ srcbE[31]);
                        negR    <= signedE && srcaE[31];
                        divZero <= multordivE && (srcbE == 32'd0);
                        count   <= 6'd0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        if (hiweW) hi <= wdataW;
                        if (loweW) lo <= wdataW;
                    end
                end
                RUN: begin
                    if (abortE) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        acc   <= stepAcc;
                        count <= count + 6'd1;
                        if (count == 6'(MULDIV_STEPS - 1)) state <= FIX;
                    end
                end
                FIX: begin
                    if (!abortE) begin
                        hi   <= hiRes;
                        lo   <= loRes;
                        done <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        startE = 1'b0, multordivE = 1'b0, signedE = 1'b0, abortE = 1'b0;
    logic        hiweW = 1'b0, loweW = 1'b0;
    logic [31:0] srcaE = '0, srcbE = '0, wdataW = '0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          errors = 0, checks = 0;

    muldiv_unit dut (
        .clk(clk), .reset(reset), .startE(startE), .multordivE(multordivE), .signedE(signedE),
        .srcaE(srcaE), .srcbE(srcbE), .abortE(abortE), .hiweW(hiweW), .loweW(loweW),
        .wdataW(wdataW), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic mord, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        logic [63:0] p;
        if (!mord) begin
            if (sgn) p = longint'($signed(a)) * longint'($signed(b));
            else     p = {32'd0, a} * {32'd0, b};
            return p;
        end
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        x = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        y = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic startOp(input logic mord, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        startE = 1'b1; multordivE = mord; signedE = sgn; srcaE = a; srcbE = b;
        @(negedge clk);
        startE = 1'b0;
    endtask

    task automatic runOp(input string name, input logic mord, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b, input bit interfere);
        logic [63:0] exp;
        int busyCycles, donePulses;
        exp = model(mord, sgn, a, b);
        busyCycles = 0;
        donePulses = 0;
        startOp(mord, sgn, a, b);
        for (int i = 0; i < 36; i++) begin
            busyCycles += int'(busy);
            donePulses += int'(done);
            if (interfere && i == 3) begin
                startE = 1'b1; multordivE = ~mord; srcaE = ~a; srcbE = b + 32'd1;
                hiweW = 1'b1; loweW = 1'b1; wdataW = 32'hDEADBEEF;
            end
            if (interfere && i == 4) begin
                startE = 1'b0; hiweW = 1'b0; loweW = 1'b0;
            end
            @(negedge clk);
        end
        chk({name, ".hi"}, 64'(hi), 64'(exp[63:32]));
        chk({name, ".lo"}, 64'(lo), 64'(exp[31:0]));
        chk({name, ".busyCycles"}, 64'(busyCycles), 64'd33);
        chk({name, ".donePulses"}, 64'(donePulses), 64'd1);
    endtask

    initial begin
        int doneSeen;
        logic [31:0] a, b;
        #12;
        chk("reset.hi", 64'(hi), 64'd0);
        chk("reset.lo", 64'(lo), 64'd0);
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // mthi then an aborted multiply
        @(negedge clk);
        hiweW = 1'b1; wdataW = 32'hAAAA5555;
        @(negedge clk);
        hiweW = 1'b0;
        chk("mthi.hi", 64'(hi), 64'hAAAA5555);
        chk("mthi.lo", 64'(lo), 64'd0);
        startOp(1'b0, 1'b1, 32'd123, 32'd456);
        for (int i = 1; i < 10; i++) @(negedge clk);
        chk("abort.busyBefore", 64'(busy), 64'd1);
        abortE = 1'b1;
        @(negedge clk);
        abortE = 1'b0;
        chk("abort.busy", 64'(busy), 64'd0);
        doneSeen = 0;
        for (int i = 0; i < 30; i++) begin
            doneSeen += int'(done);
            @(negedge clk);
        end
        chk("abort.done", 64'(doneSeen), 64'd0);
        chk("abort.hi", 64'(hi), 64'hAAAA5555);
        chk("abort.lo", 64'(lo), 64'd0);

        // abort together with start in IDLE: nothing starts
        @(negedge clk);
        abortE = 1'b1; startE = 1'b1; multordivE = 1'b0; srcaE = 32'd3; srcbE = 32'd3;
        @(negedge clk);
        abortE = 1'b0; startE = 1'b0;
        chk("abortStart.busy", 64'(busy), 64'd0);

        runOp("mult7xm3", 1'b0, 1'b1, 32'd7, 32'hFFFFFFFD, 1'b0);
        chk("mult7xm3.hiConst", 64'(hi), 64'hFFFFFFFF);
        chk("mult7xm3.loConst", 64'(lo), 64'hFFFFFFEB);
        runOp("divu100by7", 1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
        chk("divu100by7.loConst", 64'(lo), 64'd14);
        chk("divu100by7.hiConst", 64'(hi), 64'd2);
        runOp("divm7by2", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 1'b0);
        chk("divm7by2.loConst", 64'(lo), 64'hFFFFFFFD);
        chk("divm7by2.hiConst", 64'(hi), 64'hFFFFFFFF);
        runOp("divuZero", 1'b1, 1'b0, 32'h12345678, 32'd0, 1'b0);
        chk("divuZero.loConst", 64'(lo), 64'hFFFFFFFF);
        chk("divuZero.hiConst", 64'(hi), 64'h12345678);
        runOp("divsZero", 1'b1, 1'b1, 32'h87654321, 32'd0, 1'b0);
        chk("divsZero.hiConst", 64'(hi), 64'h87654321);
        runOp("divOvf", 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("divOvf.loConst", 64'(lo), 64'h80000000);
        chk("divOvf.hiConst", 64'(hi), 64'd0);
        runOp("interfere", 1'b1, 1'b0, 32'd1000, 32'd9, 1'b1);

        // asynchronous reset in the middle of an operation
        startOp(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int i = 1; i < 20; i++) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midReset.hi", 64'(hi), 64'd0);
        chk("midReset.lo", 64'(lo), 64'd0);
        chk("midReset.busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midReset.idle", 64'(busy), 64'd0);

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 20);
                2: a = $urandom_range(0, 1000);
                3: b = -$urandom_range(1, 20);
                default: ;
            endcase
            runOp($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
